// File: rtl/baud_gen_frac_if.sv
// baud_gen_frac_if: control/tick bundle between the register block, the UART
// engines and the fractional baud generator.
//   master : drives enable/sync/div_load/div_int/div_frac, reads the ticks
//   slave  : the generator; reads controls, drives os_tick/baud_tick/
//            mid_tick/os_phase
interface baud_gen_frac_if #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4,
  parameter int PH_W   = 4
);
  logic              enable;
  logic              sync;
  logic              div_load;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              os_tick;
  logic              baud_tick;
  logic              mid_tick;
  logic [PH_W-1:0]   os_phase;

  modport master (
    output enable, sync, div_load, div_int, div_frac,
    input  os_tick, baud_tick, mid_tick, os_phase
  );

  modport slave (
    input  enable, sync, div_load, div_int, div_frac,
    output os_tick, baud_tick, mid_tick, os_phase
  );
endinterface

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: runtime-programmable fractional baud-rate generator.
// Produces a one-cycle oversample tick every act_int (+carry) clocks, a bit
// tick on every OVERSAMPLE-th oversample tick and a mid-bit tick on the
// (OVERSAMPLE/2)-th. sync or enable low restart the bit phase.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      baud_gen_frac_if.slave (enable, sync, div_load, div_int,
//            div_frac in; os_tick, baud_tick, mid_tick, os_phase out)
// Build option: define BAUD_GEN_FRAC_EN to include the fractional
// accumulator; without it the period is act_int exactly and div_frac is
// ignored.
module baud_gen_frac #(
  parameter  int CNT_W      = 16,
  parameter  int FRAC_W     = 4,
  parameter  int OVERSAMPLE = 16,
  parameter  int DEF_INT    = 54,
  parameter  int DEF_FRAC   = 4,
  localparam int PH_W       = $clog2(OVERSAMPLE)
) (
  input  logic           clk,
  input  logic           reset_n,
  baud_gen_frac_if.slave bus
);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_PMID = PH_W'(OVERSAMPLE / 2 - 1);

  logic [CNT_W-1:0] cnt, act_int, pend_int, eff_int;
  logic [CNT_W:0]   period;
  logic [PH_W-1:0]  os_phase;
  logic             os_tick, baud_tick, mid_tick;
  logic             run, bnd;

  // sync and enable-low both act as "hold in restart"
  assign run     = bus.enable && !bus.sync;
  assign eff_int = (act_int == '0) ? CNT_W'(1) : act_int;

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc, act_frac, pend_frac;
  logic              carry;

  assign period = {1'b0, eff_int} + (CNT_W+1)'(carry);

  // carry computed on a boundary stretches the following period by one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      carry     <= 1'b0;
      act_frac  <= FRAC_W'(DEF_FRAC);
      pend_frac <= FRAC_W'(DEF_FRAC);
    end else begin
      if (!run) begin
        acc   <= '0;
        carry <= 1'b0;
      end else if (bnd) begin
        {carry, acc} <= {1'b0, acc} + {1'b0, act_frac};
      end
      if (bus.div_load) pend_frac <= bus.div_frac;
      if (bus.div_load && !run) act_frac <= bus.div_frac;
      else if (run && bnd)      act_frac <= pend_frac;
    end
  end
`else
  assign period = {1'b0, eff_int};
  wire unused_frac = ^{bus.div_frac, FRAC_W'(DEF_FRAC)};
`endif

  assign bnd = ({1'b0, cnt} == period - (CNT_W+1)'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      os_phase  <= '0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      mid_tick  <= 1'b0;
      act_int   <= CNT_W'(DEF_INT);
      pend_int  <= CNT_W'(DEF_INT);
    end else begin
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      mid_tick  <= 1'b0;
      if (!run) begin
        cnt      <= '0;
        os_phase <= '0;
      end else if (bnd) begin
        cnt       <= '0;
        os_tick   <= 1'b1;
        baud_tick <= (os_phase == PH_LAST);
        mid_tick  <= (os_phase == PH_PMID);
        os_phase  <= (os_phase == PH_LAST) ? '0 : os_phase + PH_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // pending divisor swaps in only on a boundary, so a running period is
      // never cut short; while held it takes effect at once
      if (bus.div_load) pend_int <= bus.div_int;
      if (bus.div_load && !run) act_int <= bus.div_int;
      else if (run && bnd)      act_int <= pend_int;
    end
  end

  assign bus.os_tick   = os_tick;
  assign bus.baud_tick = baud_tick;
  assign bus.mid_tick  = mid_tick;
  assign bus.os_phase  = os_phase;
endmodule

// File: tb/tb_baud_gen_frac.sv
module tb_baud_gen_frac;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  baud_gen_frac_if #(.CNT_W(16), .FRAC_W(4), .PH_W(4)) bus ();

  baud_gen_frac #(
    .CNT_W(16), .FRAC_W(4), .OVERSAMPLE(16), .DEF_INT(54), .DEF_FRAC(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // expected tick times after a restart with 54.4
`ifdef BAUD_GEN_FRAC_EN
  localparam int T5 = 271, T8 = 433, T16 = 867, T32 = 1735;
`else
  localparam int T5 = 270, T8 = 432, T16 = 864, T32 = 1728;
`endif

  int n_cmp = 0, n_err = 0;
  int cyc, nt, nb, nm;
  int tt[64];
  int bt[8];
  int mt[8];

  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task clr();
    cyc = 0; nt = 0; nb = 0; nm = 0;
    foreach (tt[i]) tt[i] = -1;
    foreach (bt[i]) bt[i] = -1;
    foreach (mt[i]) mt[i] = -1;
  endtask

  task step();
    @(posedge clk); #1;
    cyc++;
    if (bus.os_tick) begin
      if (nt < 64) tt[nt] = cyc;
      nt++;
    end
    if (bus.baud_tick) begin
      if (nb < 8) bt[nb] = cyc;
      nb++;
    end
    if (bus.mid_tick) begin
      if (nm < 8) mt[nm] = cyc;
      nm++;
    end
  endtask

  // sync sampled at the next edge = edge 0
  task restart();
    bus.sync = 1'b1;
    @(posedge clk); #1;
    bus.sync = 1'b0;
    bus.div_load = 1'b0;
    clr();
  endtask

  task run_until(input int n, input int limit);
    while (nt < n && cyc < limit) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1;
    bus.enable = 1'b0; bus.sync = 1'b0; bus.div_load = 1'b0;
    bus.div_int = '0;  bus.div_frac = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_os", bus.os_tick, 0);
    chk("rst_baud", bus.baud_tick, 0);
    chk("rst_mid", bus.mid_tick, 0);
    chk("rst_phase", bus.os_phase, 0);
    #20 reset_n = 1'b1;

    // enable low holds everything
    clr();
    repeat (60) step();
    chk("hold_no_tick", nt, 0);

    // defaults 54.4
    bus.enable = 1'b1;
    restart();
    run_until(5, 400);
    chk("def_t1", tt[0], 54);
    chk("def_t2", tt[1], 108);
    chk("def_t3", tt[2], 162);
    chk("def_t4", tt[3], 216);
    chk("def_t5", tt[4], T5);
    chk("def_phase5", bus.os_phase, 5);
    run_until(32, 2000);
    chk("def_mid1", mt[0], T8);
    chk("def_baud1", bt[0], T16);
    chk("def_baud2", bt[1], T32);
    chk("def_nbaud", nb, 2);
    chk("def_nmid", nm, 2);

    // load 10.0 mid-period: running period untouched
    restart();
    repeat (30) step();
    bus.div_int = 16'd10; bus.div_frac = 4'd0; bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    run_until(3, 200);
    chk("ld_t1", tt[0], 54);
    chk("ld_t2", tt[1], 64);
    chk("ld_t3", tt[2], 74);

    // load 12.0 while disabled, then enable
    bus.enable = 1'b0;
    step();
    bus.div_int = 16'd12; bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    clr();
    repeat (5) step();
    chk("dis_no_tick", nt, 0);
    chk("dis_phase", bus.os_phase, 0);
    bus.enable = 1'b1;
    clr();
    run_until(2, 100);
    chk("en_t1", tt[0], 12);
    chk("en_t2", tt[1], 24);

    // back to 54.4 via load+sync, then sync at phase 7, cycle 20
    bus.div_int = 16'd54; bus.div_frac = 4'd4; bus.div_load = 1'b1;
    restart();
    run_until(7, 1000);
    repeat (19) step();
    chk("sy_phase_pre", bus.os_phase, 7);
    restart();
    chk("sy_tick", bus.os_tick, 0);
    chk("sy_phase", bus.os_phase, 0);
    run_until(1, 200);
    chk("sy_next", tt[0], 54);

    // sync on a boundary suppresses that tick
    restart();
    repeat (53) step();
    chk("syb_pre", nt, 0);
    restart();
    chk("syb_tick", bus.os_tick, 0);
    chk("syb_phase", bus.os_phase, 0);
    run_until(1, 200);
    chk("syb_next", tt[0], 54);

    // div_int 0 behaves as 1
    bus.div_int = 16'd0; bus.div_frac = 4'd0; bus.div_load = 1'b1;
    restart();
    repeat (32) step();
    chk("d0_n", nt, 32);
    chk("d0_t1", tt[0], 1);
    chk("d0_t32", tt[31], 32);
    chk("d0_mid", mt[0], 8);
    chk("d0_baud1", bt[0], 16);
    chk("d0_baud2", bt[1], 32);

    bus.div_int = 16'd1; bus.div_load = 1'b1;
    restart();
    repeat (32) step();
    chk("d1_n", nt, 32);
    chk("d1_baud1", bt[0], 16);
    chk("d1_baud2", bt[1], 32);

    // async reset while os_tick high
    chk("ar_pre_tick", bus.os_tick, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_os", bus.os_tick, 0);
    chk("ar_baud", bus.baud_tick, 0);
    chk("ar_mid", bus.mid_tick, 0);
    chk("ar_phase", bus.os_phase, 0);
    #1 reset_n = 1'b1;
    restart();
    run_until(5, 400);
    chk("ar_t1", tt[0], 54);
    chk("ar_t4", tt[3], 216);
    chk("ar_t5", tt[4], T5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
